// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

   localparam int unsigned DEFAULT_CLKS_PER_BIT = 104;
   localparam int unsigned FRAME_DATA_BITS      = 8;

   // Two-of-three vote used to reject single-sample glitches at mid-bit.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchroniser for an asynchronous, idle-high input.
module uart_sync #(
   parameter int unsigned N = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [N-1:0] sync_q;

   // Resets to 1 so the idle line is not mistaken for a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[N-2:0], d_i};
      end
   end

   assign q_o = sync_q[N-1];

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: majority-vote mid-bit sampling, start/stop validation,
// one-entry valid/ready holding buffer with frame error, break and overrun flags.
module uart_byte_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic       clk_12,
   input  logic       rst_n,
   input  logic       uart,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       break_det
);

   localparam int unsigned TW  = $clog2(CLKS_PER_BIT);
   localparam int unsigned IW  = $clog2(FRAME_DATA_BITS);
   localparam int unsigned MID = CLKS_PER_BIT / 2;

   localparam logic [TW-1:0] T_LOAD  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] T_EARLY = TW'(MID + 1);
   localparam logic [TW-1:0] T_MID   = TW'(MID);
   localparam logic [TW-1:0] T_LATE  = TW'(MID - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_DATA_BITS - 1);

   logic                       line;
   rx_state_t                  state_q, state_d;
   logic [TW-1:0]              timer_q, timer_d;
   logic [IW-1:0]              idx_q, idx_d;
   logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
   logic [1:0]                 smp_q, smp_d;
   logic                       vote;
   logic                       deliver_c;
   logic                       ferr_c;

   logic [7:0]                 rx_data_q;
   logic                       rx_valid_q;
   logic                       frame_err_q;
   logic                       overrun_q;
   logic                       break_det_q;

   uart_sync #(
      .N (SYNC_STAGES)
   ) u_sync (
      .clk   (clk_12),
      .rst_n (rst_n),
      .d_i   (uart),
      .q_o   (line)
   );

   // Frame recovery state and bit timing.
   always_ff @(posedge clk_12 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         timer_q <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         smp_q   <= '1;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         smp_q   <= smp_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      smp_d     = smp_q;
      deliver_c = 1'b0;
      ferr_c    = 1'b0;
      vote      = maj3(smp_q[1], smp_q[0], line);

      // The first two votes are captured just before the decision point.
      if (timer_q == T_EARLY || timer_q == T_MID) begin
         smp_d = {smp_q[0], line};
      end
      if (timer_q != '0) begin
         timer_d = timer_q - 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (!line) begin
               state_d = START;
               timer_d = T_LOAD;
            end
         end
         START: begin
            if (timer_q == T_LATE && vote) begin
               state_d = IDLE;
            end else if (timer_q == '0) begin
               state_d = DATA;
               idx_d   = '0;
               timer_d = T_LOAD;
            end
         end
         DATA: begin
            if (timer_q == T_LATE) begin
               shift_d[idx_q] = vote;
            end
            if (timer_q == '0) begin
               timer_d = T_LOAD;
               if (idx_q == IDX_LAST) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         STOP: begin
            // Leaving at mid-stop lets the next start edge be caught early.
            if (timer_q == T_LATE) begin
               state_d = IDLE;
               if (vote) begin
                  deliver_c = 1'b1;
               end else if (shift_q == '0) begin
                  state_d = BREAK;
               end else begin
                  ferr_c = 1'b1;
               end
            end
         end
         BREAK: begin
            if (line) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Holding buffer and status flags.
   always_ff @(posedge clk_12 or negedge rst_n) begin
      if (!rst_n) begin
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         break_det_q <= 1'b0;
      end else begin
         frame_err_q <= ferr_c;
         overrun_q   <= 1'b0;
         break_det_q <= (state_d == BREAK);
         if (deliver_c) begin
            if (!rx_valid_q || rx_ready) begin
               rx_data_q  <= shift_q;
               rx_valid_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (rx_valid_q && rx_ready) begin
            rx_valid_q <= 1'b0;
         end
      end
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign break_det = break_det_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx with an expected/observed byte scoreboard.
module tb_uart_byte_rx;

   localparam int unsigned CPB  = 104;
   localparam int unsigned SYNC = 2;
   localparam int unsigned MID  = CPB / 2;

   logic       clk_12   = 1'b0;
   logic       rst_n    = 1'b0;
   logic       uart     = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       break_det;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   int rd = 0;

   int rise_cnt = 0;
   int ferr_cnt = 0;
   int ovr_cnt  = 0;
   int brk_cnt  = 0;
   int both_cnt = 0;
   logic valid_prev = 1'b0;

   int b_rise, b_ferr, b_ovr, b_brk, b_obs;
   int lat, n;

   uart_byte_rx #(
      .CLKS_PER_BIT (CPB),
      .SYNC_STAGES  (SYNC)
   ) dut (
      .clk_12    (clk_12),
      .rst_n     (rst_n),
      .uart      (uart),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .break_det (break_det)
   );

   always #5 clk_12 = ~clk_12;

   // Observe handshakes and flag pulses away from the active edge.
   always @(negedge clk_12) begin
      if (rx_valid && rx_ready) obs_q.push_back(rx_data);
      if (rx_valid && !valid_prev) rise_cnt <= rise_cnt + 1;
      valid_prev <= rx_valid;
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      if (overrun) ovr_cnt <= ovr_cnt + 1;
      if (frame_err && overrun) both_cnt <= both_cnt + 1;
      if (break_det) brk_cnt <= brk_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int unsigned cyc);
      repeat (cyc) @(posedge clk_12);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      uart = 1'b0;
      wait_cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         uart = b[i];
         wait_cyc(CPB);
      end
      uart = stop_bit;
      wait_cyc(CPB);
      uart = 1'b1;
   endtask

   task automatic snapshot();
      b_rise = rise_cnt;
      b_ferr = ferr_cnt;
      b_ovr  = ovr_cnt;
      b_brk  = brk_cnt;
      b_obs  = obs_q.size();
   endtask

   // Wait for every expected byte to be handed over, then compare in order.
   task automatic drain(input int budget);
      int k;
      k = 0;
      while (obs_q.size() < exp_q.size() && k < budget) begin
         wait_cyc(1);
         k++;
      end
      chk("drain_count", 32'(obs_q.size()), 32'(exp_q.size()));
      while (rd < obs_q.size() && rd < exp_q.size()) begin
         chk($sformatf("rx_byte[%0d]", rd), 32'(obs_q[rd]), 32'(exp_q[rd]));
         rd++;
      end
   endtask

   initial begin
      wait_cyc(1);
      wait_cyc(4);
      chk("reset_rx_valid", 32'(rx_valid), 32'd0);
      chk("reset_rx_data", 32'(rx_data), 32'h00);
      chk("reset_frame_err", 32'(frame_err), 32'd0);
      chk("reset_overrun", 32'(overrun), 32'd0);
      chk("reset_break_det", 32'(break_det), 32'd0);
      rst_n = 1'b1;
      wait_cyc(10);

      // Two back-to-back frames with the consumer always ready.
      snapshot();
      rx_ready = 1'b1;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h3C);
      lat = 0;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            while (!rx_valid && lat < 2000) begin
               wait_cyc(1);
               lat++;
            end
         end
      join
      chk("latency_in_window", 32'(lat >= 991 && lat <= 993), 32'd1);
      send_frame(8'h3C, 1'b1);
      wait_cyc(50);
      drain(2000);
      chk("t1_valid_pulses", 32'(rise_cnt - b_rise), 32'd2);
      chk("t1_frame_err", 32'(ferr_cnt - b_ferr), 32'd0);
      chk("t1_overrun", 32'(ovr_cnt - b_ovr), 32'd0);
      chk("t1_break", 32'(brk_cnt - b_brk), 32'd0);

      // Glitch shorter than half a bit is rejected as a false start.
      snapshot();
      uart = 1'b0;
      wait_cyc(30);
      uart = 1'b1;
      wait_cyc(150);
      chk("t2_no_valid", 32'(rise_cnt - b_rise), 32'd0);
      chk("t2_no_frame_err", 32'(ferr_cnt - b_ferr), 32'd0);
      chk("t2_no_byte", 32'(obs_q.size() - b_obs), 32'd0);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      wait_cyc(50);
      drain(2000);
      chk("t2_valid_after", 32'(rise_cnt - b_rise), 32'd1);

      // Bad stop bit: frame error, byte dropped, next frame unaffected.
      snapshot();
      send_frame(8'h3C, 1'b0);
      wait_cyc(2 * CPB);
      chk("t3_frame_err", 32'(ferr_cnt - b_ferr), 32'd1);
      chk("t3_no_valid", 32'(rise_cnt - b_rise), 32'd0);
      chk("t3_no_break", 32'(brk_cnt - b_brk), 32'd0);
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      wait_cyc(50);
      drain(2000);
      chk("t3_valid_after", 32'(rise_cnt - b_rise), 32'd1);
      chk("t3_frame_err_total", 32'(ferr_cnt - b_ferr), 32'd1);

      // Line held low for 20 bit times: break condition.
      snapshot();
      uart = 1'b0;
      n = 0;
      while (!break_det && n < 3000) begin
         wait_cyc(1);
         n++;
      end
      chk("t4_break_rise_window", 32'(n >= 985 && n <= 1000), 32'd1);
      wait_cyc(20 * CPB - n);
      chk("t4_break_held", 32'(break_det), 32'd1);
      uart = 1'b1;
      n = 0;
      while (break_det && n < 50) begin
         wait_cyc(1);
         n++;
      end
      chk("t4_break_fall", 32'(n), 32'(SYNC + 1));
      wait_cyc(2 * CPB);
      chk("t4_no_valid", 32'(rise_cnt - b_rise), 32'd0);
      chk("t4_no_frame_err", 32'(ferr_cnt - b_ferr), 32'd0);

      // Consumer stalled: first byte held, later bytes overrun.
      snapshot();
      rx_ready = 1'b0;
      exp_q.push_back(8'h01);
      send_frame(8'h01, 1'b1);
      send_frame(8'h02, 1'b1);
      send_frame(8'h03, 1'b1);
      wait_cyc(50);
      chk("t5_valid_held", 32'(rx_valid), 32'd1);
      chk("t5_data_held", 32'(rx_data), 32'h01);
      chk("t5_overrun", 32'(ovr_cnt - b_ovr), 32'd2);
      chk("t5_no_transfer", 32'(obs_q.size() - b_obs), 32'd0);
      rx_ready = 1'b1;
      wait_cyc(1);
      rx_ready = 1'b0;
      chk("t5_valid_drop", 32'(rx_valid), 32'd0);
      drain(10);
      rx_ready = 1'b1;
      exp_q.push_back(8'h04);
      send_frame(8'h04, 1'b1);
      wait_cyc(50);
      drain(2000);
      chk("t5_overrun_total", 32'(ovr_cnt - b_ovr), 32'd2);

      // Reset during data bit 4 of 0xFF aborts the frame.
      snapshot();
      uart = 1'b0;
      wait_cyc(CPB);
      for (int i = 0; i < 4; i++) begin
         uart = 1'b1;
         wait_cyc(CPB);
      end
      uart = 1'b1;
      wait_cyc(MID);
      rst_n = 1'b0;
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(2 * CPB);
      chk("t6_no_valid", 32'(rx_valid), 32'd0);
      chk("t6_data_reset", 32'(rx_data), 32'h00);
      chk("t6_no_pulse", 32'(rise_cnt - b_rise), 32'd0);
      exp_q.push_back(8'h77);
      send_frame(8'h77, 1'b1);
      wait_cyc(50);
      drain(2000);
      chk("t6_data_final", 32'(rx_data), 32'h77);
      chk("t6_frame_err", 32'(ferr_cnt - b_ferr), 32'd0);
      chk("t6_overrun", 32'(ovr_cnt - b_ovr), 32'd0);
      chk("t6_break", 32'(brk_cnt - b_brk), 32'd0);

      chk("flags_never_together", 32'(both_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
